// File: rtl/obi_sbr_regbank_pkg.sv
// Shared OBI types and Bar slot constants for the register-bank subordinate.
// Request/response channel layouts plus the FIFO entry type for buffered responses.
package obi_sbr_regbank_pkg;

  localparam logic [31:0] BarAddrOffset = 32'h2000_0000;
  localparam int          BarNumWords   = 8;
  localparam int          AidWidth      = 4;

  typedef struct packed {
    logic [31:0]         addr;
    logic                we;
    logic [3:0]          be;
    logic [31:0]         wdata;
    logic [AidWidth-1:0] aid;
    logic                a_optional;
  } sbr_obi_a_chan_t;

  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
    logic            rready;
  } sbr_obi_req_t;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [AidWidth-1:0] rid;
    logic                err;
    logic                r_optional;
  } sbr_obi_r_chan_t;

  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;

  typedef struct packed {
    logic [31:0]         rdata;
    logic [AidWidth-1:0] rid;
    logic                err;
  } sbr_obi_rsp_entry_t;

endpackage

// File: rtl/obi_rsp_fifo.sv
// Generic synchronous FIFO of Depth entries of type T; head visible combinationally.
// Latency 1 cycle push-to-output; push ignored when full unless a pop happens the same edge.
module obi_rsp_fifo #(
  parameter type T     = logic,
  parameter int  Depth = 2,
  localparam int CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push_i,
  input  T                data_i,
  input  logic            pop_i,
  output T                data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int              PtrW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr  = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);

  T                mem_q [Depth];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  assign full_o  = (count_q == DepthCnt);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  // Pointers wrap explicitly so non-power-of-2 depths work.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
      if (do_pop)  rptr_q <= (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/obi_sbr_regbank.sv
// OBI subordinate with NumWords byte-writable 32-bit registers; bad addresses answer err=1.
// Response 1 cycle after accept via FIFO; gnt drops when RspDepth responses are unreturned.
module obi_sbr_regbank
  import obi_sbr_regbank_pkg::*;
#(
  parameter int          NumWords = BarNumWords,
  parameter logic [31:0] BaseAddr = BarAddrOffset,
  parameter int          RspDepth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  sbr_obi_req_t             obi_req_i,
  output sbr_obi_rsp_t             obi_rsp_o,
  output logic [NumWords*32-1:0]   regs_o
);

  localparam int              IdxW       = $clog2(NumWords);
  localparam logic [31:0]     RangeBytes = 32'(NumWords * 4);
  localparam int              CntW       = $clog2(RspDepth + 1);
  localparam logic [CntW-1:0] DepthCnt   = CntW'(RspDepth);

  logic [31:0]        regs_q [NumWords];
  logic [31:0]        off;
  logic               addr_ok;
  logic [IdxW-1:0]    idx;
  logic               gnt, accept, pop;
  sbr_obi_rsp_entry_t push_entry, head_entry;
  logic [CntW-1:0]    fifo_count;
  logic               fifo_full, fifo_empty;
  logic               unused_sig;

  // Subtraction wraps, so addresses below BaseAddr land far out of range.
  assign off     = obi_req_i.a.addr - BaseAddr;
  assign addr_ok = (off < RangeBytes) && (obi_req_i.a.addr[1:0] == 2'b00);
  assign idx     = off[2 +: IdxW];

  assign gnt    = (fifo_count < DepthCnt);
  assign accept = obi_req_i.req && gnt;
  assign pop    = !fifo_empty && obi_req_i.rready;

  always_comb begin
    push_entry     = '0;
    push_entry.rid = obi_req_i.a.aid;
    push_entry.err = !addr_ok;
    if (addr_ok && !obi_req_i.a.we) push_entry.rdata = regs_q[idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumWords; i++) regs_q[i] <= '0;
    end else if (accept && addr_ok && obi_req_i.a.we) begin
      for (int k = 0; k < 4; k++) begin
        if (obi_req_i.a.be[k]) regs_q[idx][8*k +: 8] <= obi_req_i.a.wdata[8*k +: 8];
      end
    end
  end

  obi_rsp_fifo #(
    .T     (sbr_obi_rsp_entry_t),
    .Depth (RspDepth)
  ) u_rsp_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (accept),
    .data_i  (push_entry),
    .pop_i   (pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // r fields are forced to zero while nothing is pending.
  always_comb begin
    obi_rsp_o        = '0;
    obi_rsp_o.gnt    = gnt;
    obi_rsp_o.rvalid = !fifo_empty;
    if (!fifo_empty) begin
      obi_rsp_o.r.rdata = head_entry.rdata;
      obi_rsp_o.r.rid   = head_entry.rid;
      obi_rsp_o.r.err   = head_entry.err;
    end
  end

  for (genvar i = 0; i < NumWords; i++) begin : g_regs_out
    assign regs_o[32*i +: 32] = regs_q[i];
  end

  assign unused_sig = ^{fifo_full, obi_req_i.a.a_optional};

endmodule

// File: tb/tb_obi_sbr_regbank.sv
// Bench for obi_sbr_regbank: directed scenarios plus randomized traffic against a queue model.
module tb_obi_sbr_regbank;
  import obi_sbr_regbank_pkg::*;

  localparam logic [31:0] BASE  = 32'h2000_0000;
  localparam int          NW    = 8;
  localparam int          DEPTH = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  sbr_obi_req_t      req_s;
  sbr_obi_rsp_t      rsp_s;
  logic [NW*32-1:0]  regs_o;

  int checks = 0;
  int errors = 0;

  logic [31:0]        mregs [NW];
  sbr_obi_rsp_entry_t exp_q [$];

  obi_sbr_regbank dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .obi_req_i (req_s),
    .obi_rsp_o (rsp_s),
    .regs_o    (regs_o)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic r, input logic [31:0] a, input logic w,
                       input logic [3:0] b, input logic [31:0] d, input logic [3:0] id);
    req_s.req          = r;
    req_s.a.addr       = a;
    req_s.a.we         = w;
    req_s.a.be         = b;
    req_s.a.wdata      = d;
    req_s.a.aid        = id;
    req_s.a.a_optional = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (rsp_s.rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b want 0", rsp_s.rvalid); end
    checks++; if (rsp_s.gnt !== 1'b1) begin errors++; $display("FAIL reset_gnt: got %b want 1", rsp_s.gnt); end
    checks++; if (rsp_s.r !== '0) begin errors++; $display("FAIL reset_rfields: got %h want 0", rsp_s.r); end
    checks++; if (regs_o !== '0) begin errors++; $display("FAIL reset_regs: got %h want 0", regs_o); end
    rst = 1'b0;
  endtask

  task automatic test_write_read();
    @(negedge clk);
    req_s.rready = 1'b1;
    drive(1'b1, BASE + 32'h4, 1'b1, 4'hF, 32'hDEAD_BEEF, 4'd1);
    checks++; if (rsp_s.gnt !== 1'b1) begin errors++; $display("FAIL t1_gnt: got %b want 1", rsp_s.gnt); end
    @(negedge clk);
    checks++; if (rsp_s.rvalid !== 1'b1 || rsp_s.r.err !== 1'b0 || rsp_s.r.rid !== 4'd1 || rsp_s.r.rdata !== 32'h0)
      begin errors++; $display("FAIL t1_wr_rsp: got v=%b err=%b rid=%0d rdata=%h want v=1 err=0 rid=1 rdata=0",
                               rsp_s.rvalid, rsp_s.r.err, rsp_s.r.rid, rsp_s.r.rdata); end
    drive(1'b1, BASE + 32'h4, 1'b0, 4'h0, 32'h0, 4'd2);
    @(negedge clk);
    checks++; if (rsp_s.rvalid !== 1'b1 || rsp_s.r.rdata !== 32'hDEAD_BEEF || rsp_s.r.rid !== 4'd2)
      begin errors++; $display("FAIL t1_rd_rsp: got v=%b rdata=%h rid=%0d want v=1 rdata=deadbeef rid=2",
                               rsp_s.rvalid, rsp_s.r.rdata, rsp_s.r.rid); end
    checks++; if (regs_o[63:32] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t1_regs1: got %h want deadbeef", regs_o[63:32]); end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    @(negedge clk);
    checks++; if (rsp_s.rvalid !== 1'b0) begin errors++; $display("FAIL t1_drained: got %b want 0", rsp_s.rvalid); end
    mregs[1] = 32'hDEAD_BEEF;
  endtask

  task automatic test_byte_enable();
    @(negedge clk);
    drive(1'b1, BASE, 1'b1, 4'hF, 32'h1122_3344, 4'd3);
    @(negedge clk);
    checks++; if (rsp_s.r.rid !== 4'd3 || rsp_s.r.err !== 1'b0) begin errors++; $display("FAIL t2_wr0_rsp: got rid=%0d err=%b want 3 0", rsp_s.r.rid, rsp_s.r.err); end
    drive(1'b1, BASE, 1'b1, 4'b0101, 32'hAABB_CCDD, 4'd4);
    @(negedge clk);
    checks++; if (regs_o[31:0] !== 32'h11BB_33DD) begin errors++; $display("FAIL t2_regs0: got %h want 11bb33dd", regs_o[31:0]); end
    drive(1'b1, BASE, 1'b1, 4'b0000, 32'hFFFF_FFFF, 4'd5);
    @(negedge clk);
    drive(1'b1, BASE, 1'b0, 4'hF, 32'h0, 4'd6);
    @(negedge clk);
    checks++; if (rsp_s.r.rdata !== 32'h11BB_33DD || rsp_s.r.rid !== 4'd6)
      begin errors++; $display("FAIL t2_read: got rdata=%h rid=%0d want 11bb33dd 6", rsp_s.r.rdata, rsp_s.r.rid); end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    @(negedge clk);
    mregs[0] = 32'h11BB_33DD;
  endtask

  task automatic test_invalid();
    logic [31:0]      addrs [4];
    logic             wes [4];
    logic [NW*32-1:0] snap;
    addrs[0] = BASE + 32'h20;  wes[0] = 1'b0;
    addrs[1] = BASE + 32'h2;   wes[1] = 1'b0;
    addrs[2] = 32'h1FFF_FFFC;  wes[2] = 1'b0;
    addrs[3] = BASE + 32'h5;   wes[3] = 1'b1;
    snap = regs_o;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (rsp_s.rvalid !== 1'b1 || rsp_s.r.err !== 1'b1 || rsp_s.r.rdata !== 32'h0 || rsp_s.r.rid !== 4'(8 + i - 1))
          begin errors++; $display("FAIL t3_invalid[%0d]: got v=%b err=%b rdata=%h rid=%0d want v=1 err=1 rdata=0 rid=%0d",
                                   i - 1, rsp_s.rvalid, rsp_s.r.err, rsp_s.r.rdata, rsp_s.r.rid, 8 + i - 1); end
      end
      if (i < 4) drive(1'b1, addrs[i], wes[i], 4'hF, 32'hFFFF_FFFF, 4'(8 + i));
      else       drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    end
    checks++; if (regs_o !== snap) begin errors++; $display("FAIL t3_regs_unchanged: got %h want %h", regs_o, snap); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    req_s.rready = 1'b0;
    drive(1'b1, BASE + 32'h4, 1'b0, 4'h0, 32'h0, 4'd1);
    checks++; if (rsp_s.gnt !== 1'b1) begin errors++; $display("FAIL t4_gnt0: got %b want 1", rsp_s.gnt); end
    @(negedge clk);
    checks++; if (rsp_s.gnt !== 1'b1 || rsp_s.r.rid !== 4'd1) begin errors++; $display("FAIL t4_gnt1: got gnt=%b rid=%0d want 1 1", rsp_s.gnt, rsp_s.r.rid); end
    drive(1'b1, BASE, 1'b0, 4'h0, 32'h0, 4'd2);
    @(negedge clk);
    checks++; if (rsp_s.gnt !== 1'b0) begin errors++; $display("FAIL t4_full: got gnt=%b want 0", rsp_s.gnt); end
    drive(1'b1, BASE + 32'h4, 1'b0, 4'h0, 32'h0, 4'd3);
    @(negedge clk);
    checks++; if (rsp_s.gnt !== 1'b0 || rsp_s.r.rid !== 4'd1 || rsp_s.r.rdata !== mregs[1])
      begin errors++; $display("FAIL t4_hold: got gnt=%b rid=%0d rdata=%h want 0 1 %h", rsp_s.gnt, rsp_s.r.rid, rsp_s.r.rdata, mregs[1]); end
    req_s.rready = 1'b1;
    @(negedge clk);
    checks++; if (rsp_s.gnt !== 1'b1 || rsp_s.r.rid !== 4'd2 || rsp_s.r.rdata !== mregs[0])
      begin errors++; $display("FAIL t4_pop1: got gnt=%b rid=%0d rdata=%h want 1 2 %h", rsp_s.gnt, rsp_s.r.rid, rsp_s.r.rdata, mregs[0]); end
    @(negedge clk);
    checks++; if (rsp_s.rvalid !== 1'b1 || rsp_s.r.rid !== 4'd3 || rsp_s.r.rdata !== mregs[1])
      begin errors++; $display("FAIL t4_third: got v=%b rid=%0d rdata=%h want 1 3 %h", rsp_s.rvalid, rsp_s.r.rid, rsp_s.r.rdata, mregs[1]); end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    @(negedge clk);
    checks++; if (rsp_s.rvalid !== 1'b0) begin errors++; $display("FAIL t4_drained: got %b want 0", rsp_s.rvalid); end
  endtask

  task automatic test_back_to_back();
    req_s.rready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k > 0) begin
        checks++;
        if (rsp_s.rvalid !== 1'b1 || rsp_s.gnt !== 1'b1 || rsp_s.r.rid !== 4'(k - 1) || rsp_s.r.rdata !== mregs[(k - 1) % NW])
          begin errors++; $display("FAIL t5_stream[%0d]: got v=%b gnt=%b rid=%0d rdata=%h want 1 1 %0d %h",
                                   k, rsp_s.rvalid, rsp_s.gnt, rsp_s.r.rid, rsp_s.r.rdata, k - 1, mregs[(k - 1) % NW]); end
      end
      if (k < 10) drive(1'b1, BASE + 32'(4 * (k % NW)), 1'b0, 4'h0, 32'h0, 4'(k));
      else        drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    end
    @(negedge clk);
    checks++; if (rsp_s.rvalid !== 1'b0) begin errors++; $display("FAIL t5_no_dup: got %b want 0", rsp_s.rvalid); end
  endtask

  task automatic test_random();
    logic [31:0]        a, d, off;
    logic [3:0]         b, id;
    logic               w, rq, rr, granted, popped;
    int                 sel, idx;
    sbr_obi_rsp_entry_t e;
    @(negedge clk);
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < NW; i++) mregs[i] = 32'h0;
    exp_q.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_s.gnt !== (exp_q.size() < DEPTH) || rsp_s.rvalid !== (exp_q.size() > 0))
        begin errors++; $display("FAIL rnd_flow[%0d]: got gnt=%b rvalid=%b want pending=%0d", c, rsp_s.gnt, rsp_s.rvalid, exp_q.size()); end
      if (exp_q.size() > 0) begin
        checks++;
        if (rsp_s.r.rdata !== exp_q[0].rdata || rsp_s.r.rid !== exp_q[0].rid || rsp_s.r.err !== exp_q[0].err || rsp_s.r.r_optional !== 1'b0)
          begin errors++; $display("FAIL rnd_rsp[%0d]: got rdata=%h rid=%0d err=%b want rdata=%h rid=%0d err=%b",
                                   c, rsp_s.r.rdata, rsp_s.r.rid, rsp_s.r.err, exp_q[0].rdata, exp_q[0].rid, exp_q[0].err); end
      end else begin
        checks++;
        if (rsp_s.r !== '0) begin errors++; $display("FAIL rnd_idle_r[%0d]: got %h want 0", c, rsp_s.r); end
      end
      for (int i = 0; i < NW; i++) begin
        checks++;
        if (regs_o[32*i +: 32] !== mregs[i]) begin errors++; $display("FAIL rnd_reg%0d[%0d]: got %h want %h", i, c, regs_o[32*i +: 32], mregs[i]); end
      end
      rr  = ($urandom_range(0, 3) != 0);
      rq  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, NW - 1));
      else if (sel == 7) a = BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 3));
      else if (sel == 8) a = BASE + 32'($urandom_range(0, 4 * NW - 1));
      else               a = $urandom;
      w  = 1'($urandom_range(0, 1));
      b  = 4'($urandom);
      d  = $urandom;
      id = 4'($urandom);
      drive(rq, a, w, b, d, id);
      req_s.rready = rr;
      granted = rq && (exp_q.size() < DEPTH);
      popped  = rr && (exp_q.size() > 0);
      if (granted) begin
        off     = a - BASE;
        e.rid   = id;
        e.rdata = 32'h0;
        e.err   = !((off < 32'(4 * NW)) && (a % 4 == 0));
        if (!e.err) begin
          idx = int'(off / 4);
          if (!w) e.rdata = mregs[idx];
          else for (int k = 0; k < 4; k++) if (b[k]) mregs[idx][8*k +: 8] = d[8*k +: 8];
        end
      end
      if (popped)  void'(exp_q.pop_front());
      if (granted) exp_q.push_back(e);
    end
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    req_s.rready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rsp_s.rvalid !== (exp_q.size() > 0) || (exp_q.size() > 0 && rsp_s.r.rid !== exp_q[0].rid))
        begin errors++; $display("FAIL rnd_drain[%0d]: got rvalid=%b rid=%0d want pending=%0d", c, rsp_s.rvalid, rsp_s.r.rid, exp_q.size()); end
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    req_s.rready = 1'b0;
    drive(1'b1, BASE + 32'h8, 1'b1, 4'hF, 32'h1234_5678, 4'd1);
    @(negedge clk);
    drive(1'b1, BASE + 32'hC, 1'b1, 4'hF, 32'h9ABC_DEF0, 4'd2);
    @(negedge clk);
    drive(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 4'd0);
    checks++; if (rsp_s.rvalid !== 1'b1 || rsp_s.gnt !== 1'b0 || regs_o[95:64] !== 32'h1234_5678)
      begin errors++; $display("FAIL t6_pre: got v=%b gnt=%b reg2=%h want 1 0 12345678", rsp_s.rvalid, rsp_s.gnt, regs_o[95:64]); end
    #2 rst = 1'b1;
    #1;
    checks++; if (rsp_s.rvalid !== 1'b0 || rsp_s.gnt !== 1'b1 || regs_o !== '0 || rsp_s.r !== '0)
      begin errors++; $display("FAIL t6_async: got v=%b gnt=%b regs=%h r=%h want 0 1 0 0", rsp_s.rvalid, rsp_s.gnt, regs_o, rsp_s.r); end
    @(negedge clk);
    rst = 1'b0;
    req_s.rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (rsp_s.rvalid !== 1'b0 || rsp_s.gnt !== 1'b1)
        begin errors++; $display("FAIL t6_after[%0d]: got v=%b gnt=%b want 0 1", c, rsp_s.rvalid, rsp_s.gnt); end
    end
  endtask

  initial begin
    req_s = '0;
    for (int i = 0; i < NW; i++) mregs[i] = 32'h0;
    test_reset();
    test_write_read();
    test_byte_enable();
    test_invalid();
    test_backpressure();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
